// File: rtl/wave_writer.sv
// Byte-stream capture into the wave BRAM: assembles little-endian samples from
// a valid/ready byte source and writes them to consecutive addresses.
//
// state   | meaning
// S_IDLE  | waiting for start_in
// S_RECV  | accepting bytes of the current sample
// S_WRITE | one-cycle BRAM write of the assembled sample
// S_DONE  | one-cycle completion pulse
module wave_writer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int BRAM_DEPTH   = 4096,
  parameter int WW_WIDTH     = 12
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    start_in,
  input  logic                    abort_in,
  input  logic [WW_WIDTH-1:0]     wave_width_in,
  input  logic [7:0]              byte_in,
  input  logic                    byte_valid_in,
  output logic                    byte_ready_out,
  output logic [WW_WIDTH-1:0]     mem_addr_out,
  output logic [SAMPLE_WIDTH-1:0] mem_data_out,
  output logic                    mem_we_out,
  output logic                    busy_out,
  output logic                    done_out,
  output logic                    aborted_out,
  output logic [SAMPLE_WIDTH-1:0] checksum_out
);

  localparam int BPS  = SAMPLE_WIDTH / 8;
  localparam int BC_W = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [WW_WIDTH:0]   LP_DEPTH     = (WW_WIDTH+1)'(BRAM_DEPTH);
  localparam logic [BC_W-1:0]     LP_LAST_BYTE = BC_W'(BPS - 1);
  localparam logic [WW_WIDTH-1:0] LP_ONE       = WW_WIDTH'(1);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [WW_WIDTH-1:0]     r_width;
  logic [WW_WIDTH-1:0]     r_index;
  logic [BC_W-1:0]         r_byte_cnt;
  logic [SAMPLE_WIDTH-1:0] r_sample;
  logic [WW_WIDTH-1:0]     r_mem_addr;
  logic [SAMPLE_WIDTH-1:0] r_mem_data;
  logic                    r_mem_we;
  logic                    r_done;
  logic                    r_aborted;
  logic [SAMPLE_WIDTH-1:0] r_checksum;

  logic                    w_start;
  logic                    w_abort;
  logic                    w_accept;
  logic                    w_last_byte;
  logic                    w_write_last;
  logic [WW_WIDTH-1:0]     w_width_clamp;
  logic [SAMPLE_WIDTH-1:0] w_sample;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_start       = 1'b0;
    w_abort       = 1'b0;
    w_accept      = 1'b0;
    w_last_byte   = 1'b0;
    w_write_last  = 1'b0;
    // The comparison is one bit wider so a depth of exactly 2**WW_WIDTH still fits.
    w_width_clamp = ({1'b0, wave_width_in} > LP_DEPTH) ? LP_DEPTH[WW_WIDTH-1:0] : wave_width_in;
    w_sample      = r_sample;
    w_sample[8*int'(r_byte_cnt) +: 8] = byte_in;
    case (r_state)
      S_IDLE: begin
        if (start_in) begin
          w_start      = 1'b1;
          w_next_state = (w_width_clamp == '0) ? S_DONE : S_RECV;
        end
      end
      S_RECV: begin
        if (abort_in) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else if (byte_valid_in) begin
          w_accept = 1'b1;
          if (r_byte_cnt == LP_LAST_BYTE) begin
            w_last_byte  = 1'b1;
            w_next_state = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        if (abort_in) begin
          w_abort      = 1'b1;
          w_next_state = S_IDLE;
        end else if (r_index == r_width - LP_ONE) begin
          w_write_last = 1'b1;
          w_next_state = S_DONE;
        end else begin
          w_next_state = S_RECV;
        end
      end
      S_DONE: w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // The write strobe is registered on the last byte, so it lines up with S_WRITE.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_width    <= '0;
      r_index    <= '0;
      r_byte_cnt <= '0;
      r_sample   <= '0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
      r_mem_we   <= 1'b0;
      r_done     <= 1'b0;
      r_aborted  <= 1'b0;
      r_checksum <= '0;
    end else begin
      r_mem_we  <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= w_abort;
      if (w_start) begin
        r_width    <= w_width_clamp;
        r_index    <= '0;
        r_byte_cnt <= '0;
        r_checksum <= '0;
        r_done     <= (w_width_clamp == '0);
      end
      if (w_accept) begin
        r_sample   <= w_sample;
        r_byte_cnt <= r_byte_cnt + BC_W'(1);
      end
      if (w_last_byte) begin
        r_mem_we   <= 1'b1;
        r_mem_addr <= r_index;
        r_mem_data <= w_sample;
        r_checksum <= r_checksum + w_sample;
      end
      if (r_state == S_WRITE && !abort_in) begin
        if (w_write_last) begin
          r_done <= 1'b1;
        end else begin
          r_index    <= r_index + LP_ONE;
          r_byte_cnt <= '0;
        end
      end
    end
  end

  assign byte_ready_out = (r_state == S_RECV);
  assign busy_out       = (r_state != S_IDLE);
  assign mem_addr_out   = r_mem_addr;
  assign mem_data_out   = r_mem_data;
  assign mem_we_out     = r_mem_we;
  assign done_out       = r_done;
  assign aborted_out    = r_aborted;
  assign checksum_out   = r_checksum;

endmodule

// File: tb/tb_wave_writer.sv
// Directed bench for wave_writer: default 4096-deep instance plus an 8-deep
// instance sharing the byte stream for the depth clamp case.
module tb_wave_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        abort;
  logic [11:0] ww;
  logic [3:0]  ww8;
  logic [7:0]  byte_in;
  logic        bvalid;

  logic        rdy, we, busy, done, aborted;
  logic [11:0] addr;
  logic [15:0] data, csum;
  logic        rdy8, we8, busy8, done8, ab8;
  logic [3:0]  addr8;
  logic [15:0] data8, cs8;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;

  logic [11:0] wa[$];
  logic [15:0] wd[$];
  int          wc[$];
  int          done_cnt, done_cyc, ab_cnt, rdy_viol;
  int          w8_cnt, done8_cnt, ab8_cnt;
  logic [3:0]  w8_last;
  logic [15:0] d8_last;

  wave_writer dut (
    .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort),
    .wave_width_in(ww), .byte_in(byte_in), .byte_valid_in(bvalid),
    .byte_ready_out(rdy), .mem_addr_out(addr), .mem_data_out(data),
    .mem_we_out(we), .busy_out(busy), .done_out(done),
    .aborted_out(aborted), .checksum_out(csum)
  );

  wave_writer #(.SAMPLE_WIDTH(16), .BRAM_DEPTH(8), .WW_WIDTH(4)) dut8 (
    .clk_in(clk), .rst_in(rst), .start_in(start), .abort_in(abort),
    .wave_width_in(ww8), .byte_in(byte_in), .byte_valid_in(bvalid),
    .byte_ready_out(rdy8), .mem_addr_out(addr8), .mem_data_out(data8),
    .mem_we_out(we8), .busy_out(busy8), .done_out(done8),
    .aborted_out(ab8), .checksum_out(cs8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (we) begin
      wa.push_back(addr);
      wd.push_back(data);
      wc.push_back(cyc);
      if (rdy) rdy_viol++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (aborted) ab_cnt++;
    if (we8) begin
      w8_cnt++;
      w8_last = addr8;
      d8_last = data8;
    end
    if (done8) done8_cnt++;
    if (ab8) ab8_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0; bvalid = 1'b0;
    byte_in = 8'h00; ww = '0; ww8 = '0;
    tick();
    rst = 1'b0;
    wa.delete(); wd.delete(); wc.delete();
    done_cnt = 0; done_cyc = 0; ab_cnt = 0; rdy_viol = 0;
    w8_cnt = 0; done8_cnt = 0; ab8_cnt = 0; w8_last = '0; d8_last = '0;
  endtask

  task automatic do_start(input logic [11:0] w, input logic [3:0] w8);
    ww = w; ww8 = w8; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_bytes(input logic [7:0] b[$], input bit gaps);
    int i = 0;
    int n = 0;
    while (i < b.size() && n < 4 * b.size() + 100) begin
      byte_in = b[i];
      bvalid  = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (bvalid && rdy) i++;
      tick();
      n++;
    end
    bvalid = 1'b0;
    if (i < b.size()) begin
      vectors++; errors++;
      $display("FAIL send_bytes: sent %0d bytes, required %0d", i, b.size());
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, required 0", busy, budget);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({rdy, we, addr, data, busy, done, aborted, csum} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: rdy=%b we=%b addr=%h data=%h busy=%b done=%b ab=%b csum=%h, required all 0",
               rdy, we, addr, data, busy, done, aborted, csum);
    end
  endtask

  task automatic test_two_sample();
    do_reset();
    do_start(12'd2, 4'd2);
    vectors++;
    if (rdy !== 1'b1) begin errors++; $display("FAIL start_ready: rdy=%b, required 1", rdy); end
    send_bytes('{8'h34, 8'h12, 8'h78, 8'h56}, 1'b0);
    wait_idle(10);
    vectors++;
    if (wa.size() != 2 || wa[0] !== 12'd0 || wd[0] !== 16'h1234 || wa[1] !== 12'd1 || wd[1] !== 16'h5678) begin
      errors++;
      $display("FAIL two_writes: n=%0d (%h,%h) (%h,%h), required 2 (000,1234) (001,5678)",
               wa.size(), wa[0], wd[0], wa[1], wd[1]);
    end
    vectors++;
    if (wc[1] - wc[0] != 3) begin errors++; $display("FAIL write_spacing: %0d, required 3", wc[1] - wc[0]); end
    vectors++;
    if (csum !== 16'h68AC) begin errors++; $display("FAIL two_checksum: %h, required 68ac", csum); end
    vectors++;
    if (done_cnt != 1 || done_cyc != wc[1] + 1) begin
      errors++;
      $display("FAIL two_done: count=%0d at %0d, required 1 at %0d", done_cnt, done_cyc, wc[1] + 1);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp_d[4] = '{16'h1001, 16'h2002, 16'h3003, 16'h4004};
    do_reset();
    do_start(12'd4, 4'd4);
    send_bytes('{8'h01, 8'h10, 8'h02, 8'h20, 8'h03, 8'h30, 8'h04, 8'h40}, 1'b1);
    wait_idle(10);
    vectors++;
    if (wa.size() != 4) begin errors++; $display("FAIL bp_count: %0d writes, required 4", wa.size()); end
    for (int k = 0; k < 4; k++) begin
      vectors++;
      if (wa[k] !== 12'(k) || wd[k] !== exp_d[k]) begin
        errors++;
        $display("FAIL bp_write%0d: (%h,%h), required (%h,%h)", k, wa[k], wd[k], 12'(k), exp_d[k]);
      end
    end
    vectors++;
    if (rdy_viol != 0 || csum !== 16'hA00A || done_cnt != 1) begin
      errors++;
      $display("FAIL bp_misc: rdy_in_write=%0d csum=%h done=%0d, required 0 a00a 1", rdy_viol, csum, done_cnt);
    end
  endtask

  task automatic test_clamp_wrap();
    logic [7:0] b[$];
    do_reset();
    for (int i = 0; i < 4095; i++) begin
      b.push_back(i[7:0]);
      b.push_back(8'(i >> 8));
    end
    do_start(12'd4095, 4'd0);
    send_bytes(b, 1'b0);
    wait_idle(20);
    vectors++;
    if (wa.size() != 4095 || wa[$] !== 12'd4094 || wd[$] !== 16'd4094) begin
      errors++;
      $display("FAIL w4095_last: n=%0d last=(%h,%h), required 4095 (ffe,0ffe)", wa.size(), wa[$], wd[$]);
    end
    vectors++;
    if (done_cnt != 1 || done_cyc != wc[$] + 1 || csum !== 16'hE801) begin
      errors++;
      $display("FAIL w4095_done: done=%0d csum=%h, required 1 e801", done_cnt, csum);
    end

    do_reset();
    b.delete();
    for (int i = 1; i <= 12; i++) begin
      b.push_back(8'(i));
      b.push_back(8'h00);
    end
    do_start(12'd12, 4'd12);
    send_bytes(b, 1'b0);
    wait_idle(20);
    vectors++;
    if (w8_cnt != 8 || w8_last !== 4'd7 || d8_last !== 16'd8 || done8_cnt != 1 || ab8_cnt != 0) begin
      errors++;
      $display("FAIL depth8_clamp: n=%0d last=(%h,%h) done=%0d ab=%0d, required 8 (7,0008) 1 0",
               w8_cnt, w8_last, d8_last, done8_cnt, ab8_cnt);
    end
    vectors++;
    if (cs8 !== 16'h0024 || busy8 !== 1'b0 || rdy8 !== 1'b0 || wa.size() != 12) begin
      errors++;
      $display("FAIL depth8_misc: cs8=%h busy8=%b rdy8=%b main_n=%0d, required 0024 0 0 12",
               cs8, busy8, rdy8, wa.size());
    end

    do_reset();
    do_start(12'd2, 4'd2);
    send_bytes('{8'hFF, 8'hFF, 8'h02, 8'h00}, 1'b0);
    wait_idle(10);
    vectors++;
    if (csum !== 16'h0001) begin errors++; $display("FAIL csum_wrap: %h, required 0001", csum); end
  endtask

  task automatic test_abort();
    do_reset();
    do_start(12'd4, 4'd4);
    send_bytes('{8'h11, 8'h22, 8'h33}, 1'b0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++;
    if (aborted !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_pulse: aborted=%b busy=%b, required 1 0", aborted, busy);
    end
    tick(); tick();
    vectors++;
    if (wa.size() != 1 || wa[0] !== 12'd0 || wd[0] !== 16'h2211 || ab_cnt != 1 || done_cnt != 0) begin
      errors++;
      $display("FAIL abort_effect: n=%0d (%h,%h) ab=%0d done=%0d, required 1 (000,2211) 1 0",
               wa.size(), wa[0], wd[0], ab_cnt, done_cnt);
    end
    do_start(12'd1, 4'd1);
    vectors++;
    if (csum !== 16'h0000) begin errors++; $display("FAIL restart_csum_clear: %h, required 0000", csum); end
    send_bytes('{8'hAB, 8'hCD}, 1'b0);
    wait_idle(10);
    vectors++;
    if (wa.size() != 2 || wa[1] !== 12'd0 || wd[1] !== 16'hCDAB || csum !== 16'hCDAB || done_cnt != 1) begin
      errors++;
      $display("FAIL restart_write: n=%0d (%h,%h) csum=%h done=%0d, required 2 (000,cdab) cdab 1",
               wa.size(), wa[1], wd[1], csum, done_cnt);
    end
  endtask

  task automatic test_ignored();
    do_reset();
    byte_in = 8'hEE; bvalid = 1'b1;
    tick(); tick(); tick();
    vectors++;
    if (rdy !== 1'b0 || busy !== 1'b0 || wa.size() != 0) begin
      errors++;
      $display("FAIL idle_bytes: rdy=%b busy=%b writes=%0d, required 0 0 0", rdy, busy, wa.size());
    end
    bvalid = 1'b0;
    do_start(12'd2, 4'd2);
    ww = 12'd7;
    send_bytes('{8'h01}, 1'b0);
    ww = 12'd5; start = 1'b1;
    tick();
    start = 1'b0;
    send_bytes('{8'h02, 8'h03, 8'h04}, 1'b0);
    wait_idle(10);
    vectors++;
    if (wa.size() != 2 || wd[0] !== 16'h0201 || wd[1] !== 16'h0403 || done_cnt != 1) begin
      errors++;
      $display("FAIL start_in_recv: n=%0d d0=%h d1=%h done=%0d, required 2 0201 0403 1",
               wa.size(), wd[0], wd[1], done_cnt);
    end

    do_reset();
    ww = 12'd0; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (done !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL width0_done: done=%b busy=%b, required 1 1", done, busy);
    end
    tick(); tick();
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0 || wa.size() != 0 || done_cnt != 1) begin
      errors++;
      $display("FAIL width0_after: done=%b busy=%b writes=%0d pulses=%0d, required 0 0 0 1",
               done, busy, wa.size(), done_cnt);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    do_start(12'd3, 4'd3);
    send_bytes('{8'h11, 8'h22, 8'h33}, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({rdy, we, addr, data, busy, done, aborted, csum} !== '0) begin
      errors++;
      $display("FAIL async_reset: rdy=%b we=%b addr=%h data=%h busy=%b csum=%h, required all 0",
               rdy, we, addr, data, busy, csum);
    end
    rst = 1'b0;
    byte_in = 8'h44; bvalid = 1'b1;
    tick(); tick(); tick();
    bvalid = 1'b0;
    vectors++;
    if (wa.size() != 1 || busy !== 1'b0 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: writes=%0d busy=%b rdy=%b, required 1 0 0", wa.size(), busy, rdy);
    end
  endtask

  initial begin
    test_reset();
    test_two_sample();
    test_backpressure();
    test_clamp_wrap();
    test_abort();
    test_ignored();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wave_writer.md
# wave_writer

Streaming capture block that fills the main wave memory from an 8-bit byte source (UART/SD front end) so the wave loading path can later copy it into the oscillator and bytes-screen memories. It accepts bytes over a valid/ready handshake, assembles little-endian samples, and writes them to consecutive addresses of a BRAM write port. When the programmed number of samples has been written, it pulses `done_out`; the top level drives that pulse onto the loader's UI update trigger.

## Interface
- `SAMPLE_WIDTH`, 16, sample width in bits; must be a multiple of 8 (`BPS = SAMPLE_WIDTH/8` bytes per sample).
- `BRAM_DEPTH`, 4096, depth of the target memory.
- `WW_WIDTH`, 12, width of the sample index/count; `2**WW_WIDTH >= BRAM_DEPTH`.

Ports:
- `clk_in` input 1: system clock; the only clock.
- `rst_in` input 1: reset, asynchronous, active-high.
- `start_in` input 1: begin a capture; sampled only in IDLE.
- `abort_in` input 1: cancel the capture in progress.
- `wave_width_in` input `WW_WIDTH`: number of samples to capture; latched on start.
- `byte_in` input 8: incoming byte.
- `byte_valid_in` input 1: `byte_in` is valid.
- `byte_ready_out` output 1: block accepts a byte this cycle.
- `mem_addr_out` output `WW_WIDTH`: write address.
- `mem_data_out` output `SAMPLE_WIDTH`: write data.
- `mem_we_out` output 1: write enable; one cycle per sample.
- `busy_out` output 1: a capture is in progress (RECV, WRITE or DONE).
- `done_out` output 1: one-cycle pulse when a capture completes.
- `aborted_out` output 1: one-cycle pulse when a capture is aborted.
- `checksum_out` output `SAMPLE_WIDTH`: running sum, mod `2**SAMPLE_WIDTH`, of the samples written in the current or last capture.

## Operation
- The state machine has four states: IDLE, RECV, WRITE, DONE.
- **IDLE, on `start_in`:**
  - Latch `width = min(wave_width_in, BRAM_DEPTH)`.
  - Clear the sample index, the byte counter and `checksum_out`.
  - If `width == 0`, go to DONE. Otherwise go to RECV.
- **RECV:**
  - `byte_ready_out = 1`.
  - A byte is accepted when `byte_valid_in && byte_ready_out`. It is stored into the byte lane given by the byte counter (lane 0 = bits [7:0]).
  - When the accepted byte is byte `BPS-1`, go to WRITE.
- **WRITE (exactly one cycle):**
  - `mem_we_out = 1`, `mem_addr_out = index`, `mem_data_out` = the assembled sample.
  - `checksum_out += sample`.
  - If `index == width-1`, go to DONE. Otherwise increment `index`, clear the byte counter and return to RECV.
- **DONE (one cycle):** `done_out = 1`, then go to IDLE.
- **Abort:**
  - `abort_in` in RECV or WRITE returns the block to IDLE next cycle and pulses `aborted_out`.
  - A WRITE cycle that coincides with `abort_in` still performs its write.
  - `done_out` is not asserted for an aborted capture.
- **Ignored inputs:**
  - `start_in` outside IDLE.
  - `abort_in` in IDLE or DONE.
  - Bytes presented outside RECV are not consumed; `byte_ready_out = 0`.
- `wave_width_in` changes after the start cycle have no effect on the capture in progress.
- Arithmetic: index and width are unsigned `WW_WIDTH`-bit. The checksum wraps modulo `2**SAMPLE_WIDTH`.

## Timing
- **Reset values:** state = IDLE, and all outputs are 0: `byte_ready_out`, `mem_we_out`, `mem_addr_out`, `mem_data_out`, `busy_out`, `done_out`, `aborted_out`, `checksum_out`.
- **Output registration:**
  - All outputs are registered, except that `byte_ready_out` and `busy_out` are decoded from the registered state.
  - `mem_*` hold their last values when `mem_we_out = 0`.
- **Latency:**
  - `start_in` at cycle 0 → `byte_ready_out = 1` at cycle 1.
  - Last byte of a sample accepted at cycle n → `mem_we_out` at cycle n+1 → `byte_ready_out` again at n+2.
- **Throughput:** with `byte_valid_in` held high, one sample takes `BPS+1` cycles.
- **Completion:** the last write at cycle m → `done_out` at m+1 → IDLE at m+2. A new `start_in` is accepted from m+2.
- **Width 0:** `start_in` at cycle 0 → `done_out` at cycle 1, with no writes.
- **Reset mid-capture:** the block returns to IDLE immediately (asynchronous reset) with no further writes. Partially written memory is left as is.

## Test plan
- **Two-sample capture:** width=2, byte stream 0x34,0x12,0x78,0x56 with valid held high → writes (addr 0, 0x1234) and (addr 1, 0x5678), 3 cycles apart; `checksum_out` = 0x68AC; a single `done_out` pulse 1 cycle after the second write.
- **Back-pressure and gaps:** `byte_valid_in` toggles randomly, 4 samples → exactly 4 writes to addresses 0..3 in order with correct data; no byte is lost or duplicated; `byte_ready_out` = 0 during each WRITE cycle.
- **Clamp and wrap:**
  - Width = 4095 (BRAM_DEPTH=4096) → the last write is at addr 4094, then done.
  - With BRAM_DEPTH=8, width=12 → 8 writes (addr 0..7).
  - Checksum of 0xFFFF+0x0002 = 0x0001.
- **Abort:** abort asserted after 1.5 samples → one write (addr 0), `aborted_out` pulses, no `done_out`. A following start with width=1 writes addr 0 and resets the checksum.
- **Ignored inputs:** `start_in` during RECV and bytes during IDLE have no effect. Width=0 → `done_out` at cycle 1 with no `mem_we_out`.
- **Asynchronous reset:** `rst_in` pulsed between clock edges mid-capture → outputs are 0 before the next edge, and the state is IDLE.
